// File: rtl/id_stage_fwd.sv
// Registered MIPS decode stage: IF/ID and ID/EX registers, operand
// forwarding, ID-stage branch/jump resolution and pending-operand stall.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   if_inst, if_pc4   fetched instruction and its PC+4
//   grf_ra1/ra2       rs/rt of the IF/ID instruction to the register file
//   grf_rd1/rd2       register file read data for rs/rt
//   fwd_addr/data/rdy per-source forwarding bus, source 0 is youngest
//   stall             hold PC and IF/ID, bubble into ID/EX
//   pc_jump           redirect PC to npc_target (0 when not redirecting)
//   ex_*              ID/EX register contents
module id_stage_fwd #(
  parameter int WIDTH = 32,
  parameter int FWD_SRC = 3,
  parameter int DELAY_SLOT = 1,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              if_inst,
  input  logic [WIDTH-1:0]         if_pc4,
  input  logic [WIDTH-1:0]         grf_rd1,
  input  logic [WIDTH-1:0]         grf_rd2,
  input  logic [5*FWD_SRC-1:0]     fwd_addr,
  input  logic [WIDTH*FWD_SRC-1:0] fwd_data,
  input  logic [FWD_SRC-1:0]       fwd_ready,
  output logic [4:0]               grf_ra1,
  output logic [4:0]               grf_ra2,
  output logic                     stall,
  output logic                     pc_jump,
  output logic [WIDTH-1:0]         npc_target,
  output logic                     ex_valid,
  output logic [31:0]              ex_inst,
  output logic [WIDTH-1:0]         ex_rs,
  output logic [WIDTH-1:0]         ex_rt,
  output logic [WIDTH-1:0]         ex_imm,
  output logic [WIDTH-1:0]         ex_link
);

  localparam logic [5:0] OP_SPEC = 6'h00;
  localparam logic [5:0] OP_RIMM = 6'h01;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLEZ = 6'h06;
  localparam logic [5:0] OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ANDI = 6'h0c;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  logic [31:0]      inst_q, inst_d;
  logic [WIDTH-1:0] pc4_q, pc4_d;
  logic             valid_q, valid_d;

  logic             ex_valid_q, ex_valid_d;
  logic [31:0]      ex_inst_q, ex_inst_d;
  logic [WIDTH-1:0] ex_rs_q, ex_rs_d;
  logic [WIDTH-1:0] ex_rt_q, ex_rt_d;
  logic [WIDTH-1:0] ex_imm_q, ex_imm_d;
  logic [WIDTH-1:0] ex_link_q, ex_link_d;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt;
  logic [15:0] imm16;

  assign op    = inst_q[31:26];
  assign rs    = inst_q[25:21];
  assign rt    = inst_q[20:16];
  assign imm16 = inst_q[15:0];
  assign fn    = inst_q[5:0];

  logic is_beq, is_bne, is_blez, is_bgtz;
  logic is_bltz, is_bgez, is_j, is_jal;
  logic is_jr, is_jalr, is_zext, is_lui;
  logic use_rs, use_rt;

  assign is_beq  = op == OP_BEQ;
  assign is_bne  = op == OP_BNE;
  assign is_blez = op == OP_BLEZ;
  assign is_bgtz = op == OP_BGTZ;
  assign is_bltz = op == OP_RIMM && rt == 5'd0;
  assign is_bgez = op == OP_RIMM && rt == 5'd1;
  assign is_j    = op == OP_J;
  assign is_jal  = op == OP_JAL;
  assign is_jr   = op == OP_SPEC && fn == FN_JR;
  assign is_jalr = op == OP_SPEC && fn == FN_JALR;
  assign is_zext = op == OP_ANDI || op == OP_ORI
                || op == OP_XORI;
  assign is_lui  = op == OP_LUI;

  assign use_rs = is_beq | is_bne | is_blez | is_bgtz
                | is_bltz | is_bgez | is_jr | is_jalr;
  assign use_rt = is_beq | is_bne;

  // Returns {pending, value}. The loop runs oldest to youngest so the
  // lowest-index matching source overrides. A matching source that is
  // not ready shadows older ones; the GRF value is the best guess then.
  function automatic logic [WIDTH:0] resolve(
    input logic [4:0]               r,
    input logic [WIDTH-1:0]         grf,
    input logic [5*FWD_SRC-1:0]     fa,
    input logic [WIDTH*FWD_SRC-1:0] fd,
    input logic [FWD_SRC-1:0]       fr
  );
    logic [WIDTH:0] res;
    res = {1'b0, grf};
    for (int i = FWD_SRC - 1; i >= 0; i--) begin
      if (fa[5*i +: 5] == r) begin
        res = fr[i] ? {1'b0, fd[WIDTH*i +: WIDTH]}
                    : {1'b1, grf};
      end
    end
    if (r == 5'd0) res = '0;
    return res;
  endfunction

  logic             rs_pend, rt_pend;
  logic [WIDTH-1:0] rs_val, rt_val;

  assign {rs_pend, rs_val} =
    resolve(rs, grf_rd1, fwd_addr, fwd_data, fwd_ready);
  assign {rt_pend, rt_val} =
    resolve(rt, grf_rd2, fwd_addr, fwd_data, fwd_ready);

  logic [WIDTH-1:0] sext, imm_ext;
  logic [WIDTH-1:0] br_tgt, j_tgt, target;
  logic             rs_neg, rs_zero, taken;

  assign sext    = {{(WIDTH-16){imm16[15]}}, imm16};
  assign br_tgt  = pc4_q + (sext << 2);
  assign j_tgt   = {pc4_q[WIDTH-1:28], inst_q[25:0], 2'b00};
  assign rs_neg  = rs_val[WIDTH-1];
  assign rs_zero = rs_val == '0;

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      is_beq:  taken = rs_val == rt_val;
      is_bne:  taken = rs_val != rt_val;
      is_blez: taken = rs_neg | rs_zero;
      is_bgtz: taken = ~rs_neg & ~rs_zero;
      is_bltz: taken = rs_neg;
      is_bgez: taken = ~rs_neg;
      is_j, is_jal, is_jr, is_jalr: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    target = br_tgt;
    unique case (1'b1)
      is_j, is_jal:   target = j_tgt;
      is_jr, is_jalr: target = rs_val;
      default:        target = br_tgt;
    endcase
  end

  always_comb begin
    imm_ext = sext;
    unique case (1'b1)
      is_zext: imm_ext = WIDTH'(imm16);
      is_lui:  imm_ext = WIDTH'({imm16, 16'h0000});
      default: imm_ext = sext;
    endcase
  end

  assign stall = valid_q & ((use_rs & rs_pend)
                          | (use_rt & rt_pend));
  assign pc_jump = valid_q & ~stall & taken;
  assign npc_target = pc_jump ? target : '0;
  assign grf_ra1 = rs;
  assign grf_ra2 = rt;

  // Flush beats load; stall and pc_jump are exclusive by construction.
  always_comb begin
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (DELAY_SLOT == 0 && pc_jump) begin
      inst_d  = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      inst_d  = if_inst;
      pc4_d   = if_pc4;
      valid_d = 1'b1;
    end
  end

  logic ex_load;
  assign ex_load = valid_q & ~stall;

  always_comb begin
    ex_valid_d = ex_load;
    ex_inst_d  = '0;
    ex_rs_d    = '0;
    ex_rt_d    = '0;
    ex_imm_d   = '0;
    ex_link_d  = '0;
    if (ex_load) begin
      ex_inst_d = inst_q;
      ex_rs_d   = rs_val;
      ex_rt_d   = rt_val;
      ex_imm_d  = imm_ext;
      ex_link_d = pc4_q + WIDTH'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q     <= '0;
      pc4_q      <= RESET_PC;
      valid_q    <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_inst_q  <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      ex_imm_q   <= '0;
      ex_link_q  <= '0;
    end else begin
      inst_q     <= inst_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      ex_valid_q <= ex_valid_d;
      ex_inst_q  <= ex_inst_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      ex_imm_q   <= ex_imm_d;
      ex_link_q  <= ex_link_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_inst  = ex_inst_q;
  assign ex_rs    = ex_rs_q;
  assign ex_rt    = ex_rt_q;
  assign ex_imm   = ex_imm_q;
  assign ex_link  = ex_link_q;

endmodule
